iter_div: RTL and testbench

ITER_DIV -- requirements
Module: iter_div

---
 rtl/iter_div_pkg.sv | 23 ++
 rtl/iter_div.sv | 168 ++++++++++++++++
 tb/tb_iter_div.sv | 138 +++++++++++++
 3 files changed

// File: rtl/iter_div_pkg.sv
// Shared definitions for the iterative divider.
// Holds the FSM state encoding and the handshake constants used by iter_div.
package iter_div_pkg;

   // Handshake levels on start_i / ready_o
   localparam logic DivStart          = 1'b1;
   localparam logic DivStop           = 1'b0;
   localparam logic DivResultReady    = 1'b1;
   localparam logic DivResultNotReady = 1'b0;

   // All-zero operand word (operand width is 32 in every verified build)
   localparam logic [31:0] ZeroWord = 32'h0000_0000;

   // Divider control states; S_ZERO is only reachable in the divide-by-zero
   // detecting build.
   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_ZERO = 2'b01,
      S_CALC = 2'b10,
      S_DONE = 2'b11
   } div_state_e;

endpackage

// File: rtl/iter_div.sv
// Iterative restoring divider, signed or unsigned, one quotient bit per cycle.
// Operands are latched as magnitudes when a start is accepted; the sign fix-up
// is applied once, on the transition into DONE. The result stays valid while
// start_i is held and clears on the first edge after start_i drops.
//
// Build option: define DIV_ZERO_DETECT_EN to short-circuit a zero divisor
// through the ZERO state (result 0, ready two edges after start). Without it a
// zero divisor runs the full iteration and returns the raw restoring result.
import iter_div_pkg::*;

module iter_div #(
   parameter int DIV_W = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 signed_div_i,
   input  logic [DIV_W-1:0]     opdata1_i,
   input  logic [DIV_W-1:0]     opdata2_i,
   input  logic                 start_i,
   input  logic                 annul_i,
   output logic [2*DIV_W-1:0]   result_o,
   output logic                 ready_o
);

   div_state_e           state_reg, state_next;
   logic [DIV_W-1:0]     quo_reg, quo_next;      // dividend bits shift out, quotient bits shift in
   logic [DIV_W-1:0]     rem_reg, rem_next;      // partial remainder
   logic [DIV_W-1:0]     dvs_reg, dvs_next;      // divisor magnitude
   logic [5:0]           cnt_reg, cnt_next;      // completed iterations
   logic                 sign1_reg, sign1_next;  // dividend negative (signed mode only)
   logic                 sign2_reg, sign2_next;  // divisor negative (signed mode only)
   logic [2*DIV_W-1:0]   result_reg, result_next;
   logic                 ready_reg, ready_next;

   // Single restoring step: shift the next dividend bit into the remainder and
   // keep the subtraction only if it does not borrow.
   logic [DIV_W:0]       pr;
   logic                 borrow;
   logic [DIV_W-1:0]     sub_w;
   logic [DIV_W-1:0]     rem_step, quo_step;
   logic [DIV_W-1:0]     rem_fix, quo_fix;
   logic [DIV_W-1:0]     mag1, mag2;

   assign result_o = result_reg;
   assign ready_o  = ready_reg;

   // Datapath: one shift-subtract step, sign fix-up and operand magnitudes
   always_comb begin
      pr       = {rem_reg, quo_reg[DIV_W-1]};
      borrow   = (pr < {1'b0, dvs_reg});
      // When there is no borrow the true difference is below the divisor, so
      // the low DIV_W bits of the modular subtraction are exact.
      sub_w    = pr[DIV_W-1:0] - dvs_reg;
      rem_step = borrow ? pr[DIV_W-1:0] : sub_w;
      quo_step = {quo_reg[DIV_W-2:0], ~borrow};
      quo_fix  = (sign1_reg ^ sign2_reg) ? (~quo_step + 1'b1) : quo_step;
      rem_fix  = sign1_reg ? (~rem_step + 1'b1) : rem_step;
      mag1     = (signed_div_i && opdata1_i[DIV_W-1]) ? (~opdata1_i + 1'b1) : opdata1_i;
      mag2     = (signed_div_i && opdata2_i[DIV_W-1]) ? (~opdata2_i + 1'b1) : opdata2_i;
   end

   // Next-state and registered-output logic
   always_comb begin
      state_next  = state_reg;
      quo_next    = quo_reg;
      rem_next    = rem_reg;
      dvs_next    = dvs_reg;
      cnt_next    = cnt_reg;
      sign1_next  = sign1_reg;
      sign2_next  = sign2_reg;
      result_next = result_reg;
      ready_next  = ready_reg;

      case (state_reg)
         S_IDLE: begin
            ready_next  = DivResultNotReady;
            result_next = '0;
            if (start_i == DivStart && !annul_i) begin
               quo_next   = mag1;
               rem_next   = '0;
               dvs_next   = mag2;
               cnt_next   = '0;
               sign1_next = signed_div_i & opdata1_i[DIV_W-1];
               sign2_next = signed_div_i & opdata2_i[DIV_W-1];
`ifdef DIV_ZERO_DETECT_EN
               state_next = (opdata2_i == ZeroWord) ? S_ZERO : S_CALC;
`else
               state_next = S_CALC;
`endif
            end
         end

`ifdef DIV_ZERO_DETECT_EN
         S_ZERO: begin
            if (annul_i) begin
               state_next  = S_IDLE;
               ready_next  = DivResultNotReady;
               result_next = '0;
            end else begin
               state_next  = S_DONE;
               ready_next  = DivResultReady;
               result_next = '0;
            end
         end
`endif

         S_CALC: begin
            if (annul_i) begin
               state_next  = S_IDLE;
               ready_next  = DivResultNotReady;
               result_next = '0;
               cnt_next    = '0;
            end else begin
               quo_next = quo_step;
               rem_next = rem_step;
               cnt_next = cnt_reg + 6'd1;
               if (cnt_reg == 6'(DIV_W - 1)) begin
                  state_next  = S_DONE;
                  ready_next  = DivResultReady;
                  result_next = {rem_fix, quo_fix};
                  cnt_next    = '0;
               end
            end
         end

         S_DONE: begin
            if (annul_i || start_i == DivStop) begin
               state_next  = S_IDLE;
               ready_next  = DivResultNotReady;
               result_next = '0;
            end
         end

         default: begin
            state_next  = S_IDLE;
            ready_next  = DivResultNotReady;
            result_next = '0;
            cnt_next    = '0;
         end
      endcase
   end

   // State and output registers; reset wins over everything else
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg  <= S_IDLE;
         quo_reg    <= '0;
         rem_reg    <= '0;
         dvs_reg    <= '0;
         cnt_reg    <= '0;
         sign1_reg  <= 1'b0;
         sign2_reg  <= 1'b0;
         result_reg <= '0;
         ready_reg  <= DivResultNotReady;
      end else begin
         state_reg  <= state_next;
         quo_reg    <= quo_next;
         rem_reg    <= rem_next;
         dvs_reg    <= dvs_next;
         cnt_reg    <= cnt_next;
         sign1_reg  <= sign1_next;
         sign2_reg  <= sign2_next;
         result_reg <= result_next;
         ready_reg  <= ready_next;
      end
   end

endmodule

// File: tb/tb_iter_div.sv
// Directed self-checking bench for iter_div. Expected results are hand-computed
// constants; latency is counted in rising edges from the start-sampling edge.
// Honours DIV_ZERO_DETECT_EN for the divide-by-zero expectations.
module tb_iter_div;

   logic        clk = 1'b0;
   logic        rst;
   logic        signed_div;
   logic [31:0] op1, op2;
   logic        start, annul;
   logic [63:0] result;
   logic        ready;

   int total_cnt = 0;
   int bad_cnt   = 0;

   always #5 clk = ~clk;

   iter_div #(.DIV_W(32)) dut (
      .clk          (clk),
      .rst          (rst),
      .signed_div_i (signed_div),
      .opdata1_i    (op1),
      .opdata2_i    (op2),
      .start_i      (start),
      .annul_i      (annul),
      .result_o     (result),
      .ready_o      (ready)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total_cnt++;
      if (got !== exp) begin
         bad_cnt++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One division: drive at negedge, count edges until ready, check result,
   // optionally hold start for extra cycles, then drop start and check clear.
   task automatic run_div(input string tag, input logic sgn,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input int exp_lat,
                          input int drop_at, input int hold);
      int edges;
      @(negedge clk);
      signed_div = sgn; op1 = a; op2 = b; start = 1'b1;
      @(posedge clk); #1;
      edges = 1;
      op1 = '0; op2 = '0;   // operands must be ignored after sampling
      if (drop_at == 1) start = 1'b0;
      while (!ready && edges < 60) begin
         @(posedge clk); #1;
         edges++;
         if (edges == drop_at) start = 1'b0;
      end
      check_eq({tag, "_lat"}, 64'(edges), 64'(exp_lat));
      check_eq({tag, "_res"}, result, exp);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         check_eq({tag, "_hold_rdy"}, 64'(ready), 64'd1);
         check_eq({tag, "_hold_res"}, result, exp);
      end
      start = 1'b0;
      @(posedge clk); #1;
      check_eq({tag, "_clr_rdy"}, 64'(ready), 64'd0);
      check_eq({tag, "_clr_res"}, result, 64'd0);
      $display("div %s a=%h b=%h signed=%0d result=%h latency=%0d", tag, a, b, sgn, exp, edges);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic saw_ready;
      rst = 1'b1; start = 1'b0; annul = 1'b0; signed_div = 1'b0; op1 = '0; op2 = '0;
      repeat (2) @(posedge clk);
      #1;
      check_eq("reset_rdy", 64'(ready), 64'd0);
      check_eq("reset_res", result, 64'd0);
      rst = 1'b0;
      $display("reset released");

      run_div("u7_2",      1'b0, 32'd7,        32'd2,        {32'h0000_0001, 32'h0000_0003}, 33, 0, 0);
      run_div("s_m7_2",    1'b1, 32'hFFFF_FFF9, 32'd2,        {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33, 0, 2);
      run_div("s_min_m1",  1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0000_0000, 32'h8000_0000}, 33, 0, 0);
      run_div("u_max_16",  1'b0, 32'hFFFF_FFFF, 32'h0000_0010, {32'h0000_000F, 32'h0FFF_FFFF}, 33, 0, 0);
      run_div("s7_m2",     1'b1, 32'd7,        32'hFFFF_FFFE, {32'h0000_0001, 32'hFFFF_FFFD}, 33, 0, 0);
      run_div("u_8000_3",  1'b0, 32'h8000_0000, 32'd3,        {32'h0000_0002, 32'h2AAA_AAAA}, 33, 0, 0);
      // start dropped mid-calculation: still completes, exits one edge later
      run_div("u100_7_drop", 1'b0, 32'd100,    32'd7,        {32'h0000_0002, 32'h0000_000E}, 33, 5, 0);

`ifdef DIV_ZERO_DETECT_EN
      run_div("u5_0",      1'b0, 32'd5,        32'd0,        64'd0,                          2,  0, 0);
`else
      run_div("u5_0",      1'b0, 32'd5,        32'd0,        {32'h0000_0005, 32'hFFFF_FFFF}, 33, 0, 0);
`endif

      // Annul at CALC step 10 (edges 2..11 are steps 1..10)
      @(negedge clk);
      signed_div = 1'b0; op1 = 32'd1000; op2 = 32'd3; start = 1'b1;
      saw_ready = 1'b0;
      repeat (11) begin
         @(posedge clk); #1;
         if (ready) saw_ready = 1'b1;
      end
      annul = 1'b1;
      @(posedge clk); #1;
      check_eq("annul_rdy",   64'(ready), 64'd0);
      check_eq("annul_res",   result, 64'd0);
      check_eq("annul_early", 64'(saw_ready), 64'd0);
      annul = 1'b0; start = 1'b0;
      $display("annul at step 10 ready=%0d result=%h", ready, result);
      run_div("after_annul", 1'b0, 32'd9, 32'd4, {32'h0000_0001, 32'h0000_0002}, 33, 0, 0);

      // Reset at CALC step 20
      @(negedge clk);
      signed_div = 1'b0; op1 = 32'd12345; op2 = 32'd7; start = 1'b1;
      repeat (21) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      check_eq("rst_calc_rdy", 64'(ready), 64'd0);
      check_eq("rst_calc_res", result, 64'd0);
      rst = 1'b0; start = 1'b0;
      @(posedge clk); #1;
      check_eq("rst_idle_rdy", 64'(ready), 64'd0);
      $display("reset at step 20 ready=%0d result=%h", ready, result);
      run_div("after_rst", 1'b0, 32'd12345, 32'd7, {32'h0000_0004, 32'h0000_06E3}, 33, 0, 0);

      $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
      $finish;
   end

endmodule
